// File: rtl/bnn_pkg.sv
// Shared definitions for the BNN XNOR-popcount neuron datapath.
//   WORD_W      : activation/weight word width
//   PC_W        : popcount width for one word (0..32)
//   state_e     : neuron sequencer states
//   bipolar_dot : converts a matching-bit count over n words into the
//                 signed +1/-1 dot product (2*acc - WORD_W*n)
package bnn_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned PC_W   = 6;

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StDrain,
        StOut
    } state_e;

    function automatic int bipolar_dot(input int acc, input int n);
        return 2 * acc - int'(WORD_W) * n;
    endfunction

endpackage

// File: rtl/bnn_xnor_neuron_seq_if.sv
// Job, word-stream and result signals of one binary neuron sequencer.
//   master : job issuer / word streamer / result consumer
//   slave  : the neuron sequencer
//   start/num_words/threshold/busy  : job framing
//   in_valid/in_ready/act/wgt       : word stream
//   out_valid/out_ready/acc_out/dot_out/bit_out : result
interface bnn_xnor_neuron_seq_if #(
    parameter int unsigned WORDS_MAX = 16,
    parameter int unsigned ACC_W     = 10
);
    localparam int unsigned CNT_W = $clog2(WORDS_MAX) + 1;

    logic             start;
    logic [CNT_W-1:0] num_words;
    logic [ACC_W-1:0] threshold;
    logic             busy;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      act;
    logic [31:0]      wgt;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] acc_out;
    logic [ACC_W:0]   dot_out;
    logic             bit_out;

    modport master (
        output start, num_words, threshold, in_valid, act, wgt, out_ready,
        input  busy, in_ready, out_valid, acc_out, dot_out, bit_out
    );

    modport slave (
        input  start, num_words, threshold, in_valid, act, wgt, out_ready,
        output busy, in_ready, out_valid, acc_out, dot_out, bit_out
    );

endinterface

// File: rtl/popcount32.sv
// Purely combinational count of set bits in a 32-bit word.
//   data_i  : word to count
//   count_o : number of ones, 0..32
module popcount32
    import bnn_pkg::*;
(
    input  logic [WORD_W-1:0] data_i,
    output logic [PC_W-1:0]   count_o
);

    always_comb begin
        count_o = '0;
        for (int i = 0; i < int'(WORD_W); i++) begin
            count_o = count_o + {{(PC_W-1){1'b0}}, data_i[i]};
        end
    end

endmodule

// File: rtl/bnn_xnor_neuron_seq.sv
// Sequences one binary-neuron dot product over N words: each accepted word
// pair is XNORed and popcounted, the counts are accumulated one cycle later,
// and the total is thresholded into a binarised activation.
//   clk : rising-edge clock
//   rst : synchronous active-high reset, abandons any job in flight
//   bus : slave side of the job / word-stream / result interface
module bnn_xnor_neuron_seq
    import bnn_pkg::*;
#(
    parameter int unsigned WORDS_MAX = 16,
    parameter int unsigned ACC_W     = 10
) (
    input logic                  clk,
    input logic                  rst,
    bnn_xnor_neuron_seq_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(WORDS_MAX) + 1;

    state_e           state_q,     state_d;
    logic [CNT_W-1:0] n_q,         n_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [ACC_W-1:0] thr_q,       thr_d;
    logic [PC_W-1:0]  pc_q,        pc_d;
    logic             pc_vld_q,    pc_vld_d;
    logic [ACC_W-1:0] acc_q,       acc_d;
    logic             busy_q,      busy_d;
    logic             out_valid_q, out_valid_d;
    logic [ACC_W-1:0] acc_out_q,   acc_out_d;
    logic [ACC_W:0]   dot_out_q,   dot_out_d;
    logic             bit_out_q,   bit_out_d;

    logic [WORD_W-1:0] xn;
    logic [PC_W-1:0]   pc;
    logic              in_ready;
    logic              accept;
    logic [ACC_W-1:0]  acc_sum;
    logic [CNT_W-1:0]  n_new;

    assign xn = ~(bus.act ^ bus.wgt);

    popcount32 u_popcount32 (
        .data_i  (xn),
        .count_o (pc)
    );

    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        cnt_d       = cnt_q;
        thr_d       = thr_q;
        busy_d      = busy_q;
        out_valid_d = out_valid_q;
        acc_out_d   = acc_out_q;
        dot_out_d   = dot_out_q;
        bit_out_d   = bit_out_q;

        in_ready = (state_q == StAccum) && (cnt_q < n_q);
        accept   = bus.in_valid && in_ready;

        // Stage 1 registers this cycle's popcount; stage 2 folds it in.
        pc_d     = pc;
        pc_vld_d = accept;
        acc_sum  = acc_q + (pc_vld_q ? ACC_W'(pc_q) : '0);
        acc_d    = acc_sum;

        n_new = (bus.num_words > CNT_W'(WORDS_MAX)) ? CNT_W'(WORDS_MAX) : bus.num_words;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    n_d      = n_new;
                    thr_d    = bus.threshold;
                    cnt_d    = '0;
                    acc_d    = '0;
                    pc_vld_d = 1'b0;
                    busy_d   = 1'b1;
                    if (n_new == '0) begin
                        // Empty job: the result is known immediately.
                        state_d     = StOut;
                        out_valid_d = 1'b1;
                        acc_out_d   = '0;
                        dot_out_d   = '0;
                        bit_out_d   = (bus.threshold == '0);
                    end else begin
                        state_d = StAccum;
                    end
                end
            end
            StAccum: begin
                if (accept) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q + CNT_W'(1) == n_q) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                // acc_sum already includes the last word's popcount.
                state_d     = StOut;
                out_valid_d = 1'b1;
                acc_out_d   = acc_sum;
                dot_out_d   = (ACC_W+1)'(bipolar_dot(int'(acc_sum), int'(n_q)));
                bit_out_d   = (acc_sum >= thr_q);
            end
            StOut: begin
                if (bus.out_ready) begin
                    state_d     = StIdle;
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            n_q         <= '0;
            cnt_q       <= '0;
            thr_q       <= '0;
            pc_q        <= '0;
            pc_vld_q    <= 1'b0;
            acc_q       <= '0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            acc_out_q   <= '0;
            dot_out_q   <= '0;
            bit_out_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            cnt_q       <= cnt_d;
            thr_q       <= thr_d;
            pc_q        <= pc_d;
            pc_vld_q    <= pc_vld_d;
            acc_q       <= acc_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            acc_out_q   <= acc_out_d;
            dot_out_q   <= dot_out_d;
            bit_out_q   <= bit_out_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.busy      = busy_q;
    assign bus.out_valid = out_valid_q;
    assign bus.acc_out   = acc_out_q;
    assign bus.dot_out   = dot_out_q;
    assign bus.bit_out   = bit_out_q;

endmodule

// File: tb/tb_bnn_xnor_neuron_seq.sv
// Self-checking bench for bnn_xnor_neuron_seq: directed jobs plus randomized
// jobs, each compared against a word-list reference computed with $countones.
module tb_bnn_xnor_neuron_seq;

    localparam int WM = 16;
    localparam int AW = 10;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bnn_xnor_neuron_seq_if #(.WORDS_MAX(WM), .ACC_W(AW)) bus ();

    bnn_xnor_neuron_seq #(.WORDS_MAX(WM), .ACC_W(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] act_w [WM+1];
    logic [31:0] wgt_w [WM+1];

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete job: start, stream words, optional out_ready back-pressure,
    // then the result handshake. Starts and ends 1 time unit after an edge.
    task automatic run_job(input int n_req, input int thr, input bit gaps,
                           input int hold, input bit overrun);
        int n_eff;
        int exp_acc;
        int exp_dot;
        int exp_bit;
        int idx;
        int cyc;
        int dot;

        n_eff   = (n_req > WM) ? WM : n_req;
        exp_acc = 0;
        for (int i = 0; i < n_eff; i++) begin
            exp_acc += $countones(~(act_w[i] ^ wgt_w[i]));
        end
        exp_dot = 2 * exp_acc - 32 * n_eff;
        exp_bit = (exp_acc >= thr) ? 1 : 0;

        bus.start     = 1'b1;
        bus.num_words = 5'(n_req);
        bus.threshold = 10'(thr);
        step();
        bus.start = 1'b0;
        check("busy_after_start", int'(bus.busy), 1);

        if (n_eff > 0) begin
            check("out_valid_during_accum", int'(bus.out_valid), 0);
            idx = 0;
            cyc = 0;
            while (idx < n_eff && cyc < 200) begin
                bus.in_valid = gaps ? ((cyc % 2) == 0) : 1'b1;
                bus.act      = act_w[idx];
                bus.wgt      = wgt_w[idx];
                if (bus.in_valid && bus.in_ready) idx++;
                step();
                cyc++;
            end
            check("words_accepted", idx, n_eff);
            if (overrun) begin
                bus.in_valid = 1'b1;
                bus.act      = act_w[WM];
                bus.wgt      = wgt_w[WM];
            end else begin
                bus.in_valid = 1'b0;
            end
            check("in_ready_after_last", int'(bus.in_ready), 0);
            check("out_valid_1_after_last", int'(bus.out_valid), 0);
            step();
            check("in_ready_2_after_last", int'(bus.in_ready), 0);
            check("out_valid_2_after_last", int'(bus.out_valid), 1);
            bus.in_valid = 1'b0;
        end else begin
            check("out_valid_empty_job", int'(bus.out_valid), 1);
        end

        for (int h = 0; h < hold; h++) begin
            bus.out_ready = 1'b0;
            bus.start     = ((h % 2) == 0);
            bus.num_words = 5'd3;
            step();
            check("hold_out_valid", int'(bus.out_valid), 1);
            check("hold_busy", int'(bus.busy), 1);
            check("hold_acc", int'(bus.acc_out), exp_acc);
        end
        bus.start = 1'b0;

        dot = $signed(bus.dot_out);
        check("acc_out", int'(bus.acc_out), exp_acc);
        check("dot_out", dot, exp_dot);
        check("bit_out", int'(bus.bit_out), exp_bit);
        check("acc_in_range", int'(bus.acc_out <= 10'(32 * n_eff)), 1);

        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check("out_valid_after_hs", int'(bus.out_valid), 0);
        check("busy_after_hs", int'(bus.busy), 0);
    endtask

    initial begin
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.num_words = '0;
        bus.threshold = '0;
        bus.in_valid  = 1'b0;
        bus.act       = '0;
        bus.wgt       = '0;
        bus.out_ready = 1'b0;
        step();
        step();
        check("rst_busy", int'(bus.busy), 0);
        check("rst_in_ready", int'(bus.in_ready), 0);
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_acc_out", int'(bus.acc_out), 0);
        check("rst_dot_out", int'(bus.dot_out), 0);
        check("rst_bit_out", int'(bus.bit_out), 0);
        rst = 1'b0;
        step();

        // N=1, all ones against all ones.
        act_w[0] = 32'hFFFF_FFFF;
        wgt_w[0] = 32'hFFFF_FFFF;
        run_job(1, 16, 1'b0, 0, 1'b0);

        // N=4, every bit mismatched.
        for (int i = 0; i < 4; i++) begin
            act_w[i] = 32'h0000_0000;
            wgt_w[i] = 32'hFFFF_FFFF;
        end
        run_job(4, 1, 1'b0, 0, 1'b0);

        // N=16 back-to-back, only the last word matches; a 17th word is offered.
        for (int i = 0; i < WM; i++) begin
            act_w[i] = 32'hAAAA_AAAA;
            wgt_w[i] = 32'h5555_5555;
        end
        act_w[WM-1] = 32'h1234_5678;
        wgt_w[WM-1] = 32'h1234_5678;
        act_w[WM]   = 32'hFFFF_FFFF;
        wgt_w[WM]   = 32'hFFFF_FFFF;
        run_job(16, 100, 1'b0, 0, 1'b1);

        // N=3 with in_valid gaps, popcounts 10/20/30, then back-pressure.
        act_w[0] = 32'h0;  wgt_w[0] = 32'h003F_FFFF;
        act_w[1] = 32'h0;  wgt_w[1] = 32'h0000_0FFF;
        act_w[2] = 32'h0;  wgt_w[2] = 32'h0000_0003;
        run_job(3, 60, 1'b1, 5, 1'b0);

        // Empty jobs, with and without a zero threshold.
        run_job(0, 0, 1'b0, 0, 1'b0);
        run_job(0, 5, 1'b0, 1, 1'b0);

        // Oversized N is clamped to WORDS_MAX.
        for (int i = 0; i < WM; i++) begin
            act_w[i] = $urandom();
            wgt_w[i] = $urandom();
        end
        run_job(20, 200, 1'b0, 0, 1'b0);

        // Reset mid-accumulation discards the partial sum.
        bus.start     = 1'b1;
        bus.num_words = 5'd4;
        bus.threshold = 10'd0;
        step();
        bus.start    = 1'b0;
        bus.in_valid = 1'b1;
        bus.act      = 32'hFFFF_FFFF;
        bus.wgt      = 32'hFFFF_FFFF;
        step();
        step();
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        step();
        rst = 1'b0;
        check("midrst_busy", int'(bus.busy), 0);
        check("midrst_out_valid", int'(bus.out_valid), 0);
        check("midrst_in_ready", int'(bus.in_ready), 0);
        act_w[0] = 32'hF0F0_F0F0;
        wgt_w[0] = 32'hFF00_FF00;
        run_job(1, 16, 1'b0, 0, 1'b0);

        // Randomized jobs.
        for (int j = 0; j < 24; j++) begin
            for (int i = 0; i <= WM; i++) begin
                act_w[i] = $urandom();
                wgt_w[i] = ($urandom_range(0, 3) == 0) ? act_w[i] : 32'($urandom());
            end
            run_job(int'($urandom_range(0, 18)), int'($urandom_range(0, 400)),
                    1'($urandom_range(0, 1)), int'($urandom_range(0, 2)),
                    1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
